// File: rtl/friscv_mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one
// memory channel, with alternating priority on contention and a per-access
// timeout.
module friscv_mem_arbiter #(
    parameter int unsigned ADDRW   = 16,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                inst_en,
    input  logic [ADDRW-1:0]    inst_addr,
    output logic [XLEN-1:0]     inst_rdata,
    output logic                inst_ready,
    input  logic                data_en,
    input  logic                data_wr,
    input  logic [ADDRW-1:0]    data_addr,
    input  logic [XLEN-1:0]     data_wdata,
    input  logic [XLEN/8-1:0]   data_strb,
    output logic [XLEN-1:0]     data_rdata,
    output logic                data_ready,
    output logic                mem_en,
    output logic                mem_wr,
    output logic [ADDRW-1:0]    mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_strb,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ready,
    output logic                timeout_err
);

    localparam int unsigned STRBW = XLEN / 8;
    localparam int unsigned CNTW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_INST = 2'd1,
        GRANT_DATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_data;   // 1: data was the last requester served
    logic [CNTW-1:0]   cnt;

    logic granted;
    logic done_ok;
    logic done_to;
    logic done;
    logic cnt_hit;

    // Completion decode: memory response or timeout on the final allowed cycle
    assign granted = (state != IDLE) && mem_en;
    assign cnt_hit = (cnt >= CNTW'(TIMEOUT - 1));
    assign done_ok = granted && mem_ready;
    assign done_to = granted && !mem_ready && cnt_hit;
    assign done    = done_ok || done_to;

    // Requester-side responses; suppressed while reset is asserted
    assign inst_ready = aresetn && done && (state == GRANT_INST);
    assign data_ready = aresetn && done && (state == GRANT_DATA);
    assign inst_rdata = (aresetn && done_ok && (state == GRANT_INST)) ? mem_rdata : '0;
    assign data_rdata = (aresetn && done_ok && (state == GRANT_DATA)) ? mem_rdata : '0;

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: round-robin on contention, return to IDLE after each access
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (inst_en && data_en) begin
                    state_next = last_data ? GRANT_INST : GRANT_DATA;
                end else if (inst_en) begin
                    state_next = GRANT_INST;
                end else if (data_en) begin
                    state_next = GRANT_DATA;
                end
            end
            GRANT_INST, GRANT_DATA: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory command capture, timeout counter and sticky error flag
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_strb    <= '0;
            cnt         <= '0;
            last_data   <= 1'b0;
            timeout_err <= 1'b0;
        end else if (state == IDLE && state_next == GRANT_INST) begin
            mem_en    <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= inst_addr;
            mem_wdata <= '0;
            mem_strb  <= STRBW'(0);
            cnt       <= '0;
        end else if (state == IDLE && state_next == GRANT_DATA) begin
            mem_en    <= 1'b1;
            mem_wr    <= data_wr;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            mem_strb  <= data_strb;
            cnt       <= '0;
        end else if (done) begin
            mem_en    <= 1'b0;
            last_data <= (state == GRANT_DATA);
            if (done_to) begin
                timeout_err <= 1'b1;
            end
        end else if (granted && (cnt < CNTW'(TIMEOUT))) begin
            cnt <= cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_friscv_mem_arbiter.sv
// Directed bench for friscv_mem_arbiter (TIMEOUT overridden to 4).
module tb_friscv_mem_arbiter;

    localparam int unsigned ADDRW = 16;
    localparam int unsigned XLEN  = 32;

    logic               aclk;
    logic               aresetn;
    logic               inst_en;
    logic [ADDRW-1:0]   inst_addr;
    logic [XLEN-1:0]    inst_rdata;
    logic               inst_ready;
    logic               data_en;
    logic               data_wr;
    logic [ADDRW-1:0]   data_addr;
    logic [XLEN-1:0]    data_wdata;
    logic [XLEN/8-1:0]  data_strb;
    logic [XLEN-1:0]    data_rdata;
    logic               data_ready;
    logic               mem_en;
    logic               mem_wr;
    logic [ADDRW-1:0]   mem_addr;
    logic [XLEN-1:0]    mem_wdata;
    logic [XLEN/8-1:0]  mem_strb;
    logic [XLEN-1:0]    mem_rdata;
    logic               mem_ready;
    logic               timeout_err;

    int errors = 0;
    int checks = 0;

    friscv_mem_arbiter #(.ADDRW(ADDRW), .XLEN(XLEN), .TIMEOUT(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_strb(data_strb), .data_rdata(data_rdata), .data_ready(data_ready),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .timeout_err(timeout_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance past the next rising edge; inputs are then driven mid-cycle
    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs;
        inst_en = 0; inst_addr = '0; data_en = 0; data_wr = 0; data_addr = '0;
        data_wdata = '0; data_strb = '0; mem_rdata = '0; mem_ready = 0;
    endtask

    task automatic test_reset;
        aresetn = 0;
        clear_inputs();
        step(); step();
        @(negedge aclk);
        checks++; if (mem_en !== 1'b0)      begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
        checks++; if (mem_addr !== 16'h0)   begin errors++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
        checks++; if (mem_wr !== 1'b0)      begin errors++; $display("FAIL rst_mem_wr: got %b want 0", mem_wr); end
        checks++; if (mem_wdata !== 32'h0)  begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (mem_strb !== 4'h0)    begin errors++; $display("FAIL rst_mem_strb: got %h want 0", mem_strb); end
        checks++; if (inst_ready !== 1'b0)  begin errors++; $display("FAIL rst_inst_ready: got %b want 0", inst_ready); end
        checks++; if (data_ready !== 1'b0)  begin errors++; $display("FAIL rst_data_ready: got %b want 0", data_ready); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        step();
        aresetn = 1;
    endtask

    task automatic test_inst_fetch;
        inst_en = 1; inst_addr = 16'h0010;
        step();
        @(negedge aclk);
        checks++; if (mem_en !== 1'b1)       begin errors++; $display("FAIL fetch_mem_en: got %b want 1", mem_en); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL fetch_mem_addr: got %h want 0010", mem_addr); end
        checks++; if (mem_wr !== 1'b0)       begin errors++; $display("FAIL fetch_mem_wr: got %b want 0", mem_wr); end
        checks++; if (inst_ready !== 1'b0)   begin errors++; $display("FAIL fetch_early_ready: got %b want 0", inst_ready); end
        step();
        @(negedge aclk);
        checks++; if (inst_ready !== 1'b0)   begin errors++; $display("FAIL fetch_wait_ready: got %b want 0", inst_ready); end
        step();
        mem_ready = 1; mem_rdata = 32'h0000_0013;
        @(negedge aclk);
        checks++; if (inst_ready !== 1'b1)          begin errors++; $display("FAIL fetch_ready: got %b want 1", inst_ready); end
        checks++; if (inst_rdata !== 32'h0000_0013) begin errors++; $display("FAIL fetch_rdata: got %h want 00000013", inst_rdata); end
        checks++; if (data_ready !== 1'b0)          begin errors++; $display("FAIL fetch_data_ready: got %b want 0", data_ready); end
        checks++; if (data_rdata !== 32'h0)         begin errors++; $display("FAIL fetch_data_rdata: got %h want 0", data_rdata); end
        step();
        inst_en = 0;
        @(negedge aclk);
        // mem_ready still high while mem_en is low: must be ignored
        checks++; if (mem_en !== 1'b0)      begin errors++; $display("FAIL fetch_mem_en_drop: got %b want 0", mem_en); end
        checks++; if (inst_ready !== 1'b0)  begin errors++; $display("FAIL fetch_ready_once: got %b want 0", inst_ready); end
        checks++; if (inst_rdata !== 32'h0) begin errors++; $display("FAIL fetch_rdata_gate: got %h want 0", inst_rdata); end
        step();
        @(negedge aclk);
        checks++; if (inst_ready !== 1'b0)  begin errors++; $display("FAIL fetch_stray_ready: got %b want 0", inst_ready); end
        clear_inputs();
        step();
    endtask

    task automatic test_arbitration;
        aresetn = 0;
        step();
        aresetn = 1;
        inst_en = 1; inst_addr = 16'h0020;
        data_en = 1; data_addr = 16'h0040; data_wr = 0;
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        for (int k = 1; k <= 8; k++) begin
            logic exp_en, exp_d, exp_i;
            exp_en = (k % 2) == 1;
            exp_d  = (k == 1) || (k == 5);
            exp_i  = (k == 3) || (k == 7);
            step();
            @(negedge aclk);
            checks++; if (mem_en !== exp_en)     begin errors++; $display("FAIL arb_mem_en[%0d]: got %b want %b", k, mem_en, exp_en); end
            checks++; if (data_ready !== exp_d)  begin errors++; $display("FAIL arb_data_ready[%0d]: got %b want %b", k, data_ready, exp_d); end
            checks++; if (inst_ready !== exp_i)  begin errors++; $display("FAIL arb_inst_ready[%0d]: got %b want %b", k, inst_ready, exp_i); end
            if (exp_en) begin
                checks++;
                if (mem_addr !== (exp_d ? 16'h0040 : 16'h0020)) begin
                    errors++; $display("FAIL arb_mem_addr[%0d]: got %h want %h", k, mem_addr, exp_d ? 16'h0040 : 16'h0020);
                end
            end
            if (k == 1) begin
                checks++; if (data_rdata !== 32'h1234_5678) begin errors++; $display("FAIL arb_data_rdata: got %h want 12345678", data_rdata); end
            end
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_store;
        data_en = 1; data_wr = 1; data_addr = 16'h0100;
        data_wdata = 32'hDEAD_BEEF; data_strb = 4'hF;
        step();
        @(negedge aclk);
        checks++; if (mem_en !== 1'b1)            begin errors++; $display("FAIL st_mem_en: got %b want 1", mem_en); end
        checks++; if (mem_wr !== 1'b1)            begin errors++; $display("FAIL st_mem_wr: got %b want 1", mem_wr); end
        checks++; if (mem_addr !== 16'h0100)      begin errors++; $display("FAIL st_mem_addr: got %h want 0100", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_mem_wdata: got %h want deadbeef", mem_wdata); end
        checks++; if (mem_strb !== 4'hF)          begin errors++; $display("FAIL st_mem_strb: got %h want f", mem_strb); end
        checks++; if (data_ready !== 1'b0)        begin errors++; $display("FAIL st_early_ready: got %b want 0", data_ready); end
        step();
        mem_ready = 1;
        @(negedge aclk);
        checks++; if (data_ready !== 1'b1)        begin errors++; $display("FAIL st_data_ready: got %b want 1", data_ready); end
        checks++; if (inst_ready !== 1'b0)        begin errors++; $display("FAIL st_inst_ready: got %b want 0", inst_ready); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_wdata_stable: got %h want deadbeef", mem_wdata); end
        step();
        clear_inputs();
        @(negedge aclk);
        checks++; if (mem_en !== 1'b0)            begin errors++; $display("FAIL st_mem_en_drop: got %b want 0", mem_en); end
        step();
    endtask

    task automatic test_ready_at_timeout;
        inst_en = 1; inst_addr = 16'h0030;
        step();
        @(negedge aclk);
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rat_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (mem_strb !== 4'h0)   begin errors++; $display("FAIL rat_mem_strb: got %h want 0", mem_strb); end
        step(); step(); step();
        mem_ready = 1; mem_rdata = 32'hCAFE_0001;
        @(negedge aclk);
        checks++; if (inst_ready !== 1'b1)          begin errors++; $display("FAIL rat_inst_ready: got %b want 1", inst_ready); end
        checks++; if (inst_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL rat_inst_rdata: got %h want cafe0001", inst_rdata); end
        step();
        clear_inputs();
        @(negedge aclk);
        checks++; if (mem_en !== 1'b0)      begin errors++; $display("FAIL rat_mem_en: got %b want 0", mem_en); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rat_timeout_err: got %b want 0", timeout_err); end
        step();
    endtask

    task automatic test_timeout;
        data_en = 1; data_wr = 0; data_addr = 16'h0200; mem_rdata = 32'hAAAA_5555;
        for (int k = 1; k <= 4; k++) begin
            step();
            @(negedge aclk);
            checks++; if (mem_en !== 1'b1)          begin errors++; $display("FAIL to_mem_en[%0d]: got %b want 1", k, mem_en); end
            checks++; if (data_ready !== (k == 4))  begin errors++; $display("FAIL to_data_ready[%0d]: got %b want %b", k, data_ready, k == 4); end
            checks++; if (data_rdata !== 32'h0)     begin errors++; $display("FAIL to_data_rdata[%0d]: got %h want 0", k, data_rdata); end
            checks++; if (timeout_err !== 1'b0)     begin errors++; $display("FAIL to_err_early[%0d]: got %b want 0", k, timeout_err); end
        end
        step();
        data_en = 0;
        @(negedge aclk);
        checks++; if (mem_en !== 1'b0)      begin errors++; $display("FAIL to_mem_en_drop: got %b want 0", mem_en); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
        checks++; if (data_ready !== 1'b0)  begin errors++; $display("FAIL to_ready_once: got %b want 0", data_ready); end
        inst_en = 1; inst_addr = 16'h0060;
        step();
        mem_ready = 1;
        @(negedge aclk);
        checks++; if (inst_ready !== 1'b1)  begin errors++; $display("FAIL to_next_fetch: got %b want 1", inst_ready); end
        step();
        clear_inputs();
        @(negedge aclk);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", timeout_err); end
        step();
    endtask

    task automatic test_reset_mid_grant;
        inst_en = 1; inst_addr = 16'h0050;
        step();
        aresetn = 0; mem_ready = 1; mem_rdata = 32'h0000_0077;
        @(negedge aclk);
        checks++; if (inst_ready !== 1'b0)  begin errors++; $display("FAIL rmg_inst_ready: got %b want 0", inst_ready); end
        checks++; if (data_ready !== 1'b0)  begin errors++; $display("FAIL rmg_data_ready: got %b want 0", data_ready); end
        checks++; if (inst_rdata !== 32'h0) begin errors++; $display("FAIL rmg_inst_rdata: got %h want 0", inst_rdata); end
        step();
        aresetn = 1;
        clear_inputs();
        @(negedge aclk);
        checks++; if (mem_en !== 1'b0)      begin errors++; $display("FAIL rmg_mem_en: got %b want 0", mem_en); end
        checks++; if (mem_addr !== 16'h0)   begin errors++; $display("FAIL rmg_mem_addr: got %h want 0000", mem_addr); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rmg_timeout_err: got %b want 0", timeout_err); end
        checks++; if (inst_ready !== 1'b0)  begin errors++; $display("FAIL rmg_ready_after: got %b want 0", inst_ready); end
        step();
    endtask

    initial begin
        aresetn = 0;
        clear_inputs();
        test_reset();
        test_inst_fetch();
        test_arbitration();
        test_store();
        test_ready_at_timeout();
        test_timeout();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
